// File: rtl/inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_encoder                                                  |
// | Purpose  : Assembles RV32I instruction words from opcode/register/funct  |
// |            fields and a full 32-bit signed immediate. Range-checks the   |
// |            immediate for its format and scatters it into place. Expands  |
// |            the `li rd, imm32` pseudo-instruction into one or two words   |
// |            (LUI and/or ADDI). Valid/ready handshakes on both sides.      |
// | Ports    : clk, rst (async, active-high)                                 |
// |            in_valid/in_ready, in_li, in_op, in_rd, in_rs1, in_rs2,       |
// |            in_funct3, in_funct7, in_imm            - request side        |
// |            out_valid/out_ready, out_inst, out_err, out_last - word side  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_li,
  input  logic [6:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [31:0] c_NOP       = 32'h0000_0013;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hold,  w_hold_nxt;
  logic        w_valid_nxt, w_err_nxt, w_last_nxt;
  logic [31:0] w_inst_nxt;

  // Range predicates: an immediate fits in N signed bits when all bits from
  // N-1 upward are copies of the sign.
  logic w_fits12, w_fits13, w_fits21;
  assign w_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // li upper part is rounded up when bit 11 is set, because the following
  // ADDI sign-extends its 12-bit immediate. 20-bit wrap is intentional.
  logic [19:0] w_li_upper;
  assign w_li_upper = in_imm[31:12] + {19'd0, in_imm[11]};

  // First word, its error flag, whether a second word follows, and the
  // second word itself.
  logic [31:0] w_word1, w_word2;
  logic        w_err1, w_two;

  always_comb begin
    w_word1 = c_NOP;
    w_word2 = 32'd0;
    w_err1  = 1'b0;
    w_two   = 1'b0;
    if (in_li) begin
      if (w_fits12) begin
        w_word1 = {in_imm[11:0], 5'd0, 3'b000, in_rd, c_OP_IMM};
      end else begin
        w_word1 = {w_li_upper, in_rd, c_OP_LUI};
        w_two   = |in_imm[11:0];
        w_word2 = {in_imm[11:0], in_rd, 3'b000, in_rd, c_OP_IMM};
      end
    end else begin
      case (in_op)
        c_OP_IMM: begin
          if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
            w_word1 = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
            w_err1  = |in_imm[31:5];
          end else begin
            w_word1 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            w_err1  = ~w_fits12;
          end
        end
        c_OP_LOAD, c_OP_JALR: begin
          w_word1 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
          w_err1  = ~w_fits12;
        end
        c_OP_STORE: begin
          w_word1 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
          w_err1  = ~w_fits12;
        end
        c_OP_BRANCH: begin
          w_word1 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_op};
          w_err1  = ~w_fits13 | in_imm[0];
        end
        c_OP_JAL: begin
          w_word1 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, in_op};
          w_err1  = ~w_fits21 | in_imm[0];
        end
        c_OP_LUI, c_OP_AUIPC: begin
          w_word1 = {in_imm[31:12], in_rd, in_op};
          w_err1  = |in_imm[11:0];
        end
        default: begin
          w_word1 = c_NOP;
          w_err1  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hold    <= 32'd0;
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      out_valid <= w_valid_nxt;
      out_inst  <= w_inst_nxt;
      out_err   <= w_err_nxt;
      out_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_valid_nxt = out_valid;
    w_inst_nxt  = out_inst;
    w_err_nxt   = out_err;
    w_last_nxt  = out_last;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~out_valid | out_ready;
        if (out_valid && out_ready) begin
          w_valid_nxt = 1'b0;
        end
        // A new accept overrides the drop above, giving back-to-back words.
        if (in_valid && in_ready) begin
          w_valid_nxt = 1'b1;
          w_inst_nxt  = w_word1;
          w_err_nxt   = w_err1;
          w_last_nxt  = ~w_two;
          if (w_two) begin
            w_hold_nxt  = w_word2;
            w_state_nxt = S_SECOND;
          end
        end
      end
      S_SECOND: begin
        if (out_valid && out_ready) begin
          w_valid_nxt = 1'b1;
          w_inst_nxt  = r_hold;
          w_err_nxt   = 1'b0;
          w_last_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_inst_encoder                                               |
// | Purpose  : Directed self-checking bench for inst_encoder.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_li;
  logic [6:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_err, out_last;

  int n_checks = 0;
  int n_fail   = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_li     (in_li),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Present one request for a single clock edge, then sample #1 after it.
  task automatic drive_req(input logic li, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
    in_li = li; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_err !== 1'b0 ||
        out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: valid=%b inst=%h err=%b last=%b ready=%b, want 0 0 0 0 1",
               out_valid, out_inst, out_err, out_last, in_ready);
    end
  endtask

  task automatic test_single(input string name, input logic [6:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm,
                             input logic [31:0] exp_inst, input logic exp_err);
    out_ready = 1'b1;
    drive_req(1'b0, op, rd, rs1, rs2, f3, f7, imm);
    n_checks++;
    if (out_valid !== 1'b1 || out_inst !== exp_inst || out_err !== exp_err ||
        out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: valid=%b inst=%h err=%b last=%b, want 1 %h %b 1",
               name, out_valid, out_inst, out_err, out_last, exp_inst, exp_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drop: valid=%b, want 0", name, out_valid);
    end
  endtask

  task automatic test_formats();
    test_single("imm_addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,
                32'h0050_0093, 1'b0);
    test_single("store", 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC,
                32'hFE21_AE23, 1'b0);
    test_single("branch", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,
                32'h0020_8463, 1'b0);
    test_single("branch_odd", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,
                32'h0020_8363, 1'b1);
    test_single("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800,
                32'h0010_00EF, 1'b0);
    test_single("slli31", 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd31,
                32'h01F0_9093, 1'b0);
    test_single("slli32", 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32,
                32'h0000_9093, 1'b1);
    test_single("addi_2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
                32'h8000_0093, 1'b1);
    test_single("unknown", 7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,
                32'h0000_0013, 1'b1);
    test_single("lui_low", 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001,
                32'h0000_1037, 1'b1);
  endtask

  task automatic test_li_stall();
    out_ready = 1'b0;
    drive_req(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    n_checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h1234_62B7 || out_last !== 1'b0 ||
        out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL li_word1: valid=%b inst=%h last=%b err=%b, want 1 123462b7 0 0",
               out_valid, out_inst, out_last, out_err);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;  // offered but must not be taken while stalled
      @(posedge clk); #1;
      n_checks++;
      if (out_inst !== 32'h1234_62B7 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL li_stall%0d: inst=%h last=%b ready=%b, want 123462b7 0 0",
                 i, out_inst, out_last, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'hFFF2_8293 || out_last !== 1'b1 ||
        out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL li_word2: valid=%b inst=%h last=%b err=%b, want 1 fff28293 1 0",
               out_valid, out_inst, out_last, out_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL li_drop: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_li_single();
    out_ready = 1'b1;
    drive_req(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_3000);
    n_checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0000_32B7 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL li_lui_only: valid=%b inst=%h last=%b, want 1 000032b7 1",
               out_valid, out_inst, out_last);
    end
    drive_req(1'b1, 7'h7F, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    n_checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h8000_0393 || out_last !== 1'b1 ||
        out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL li_addi: valid=%b inst=%h last=%b err=%b, want 1 80000393 1 0",
               out_valid, out_inst, out_last, out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    out_ready = 1'b1;
    in_li = 1'b0; in_op = 7'h13; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_rd  = 5'(i + 1);
      in_imm = 32'(i * 3);
      @(posedge clk); #1;
      exp = {12'(i * 3), 5'd0, 3'd0, 5'(i + 1), 7'h13};
      n_checks++;
      if (out_valid !== 1'b1 || out_inst !== exp || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b%0d: valid=%b inst=%h ready=%b, want 1 %h 1",
                 i, out_valid, out_inst, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_second();
    out_ready = 1'b0;
    drive_req(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    n_checks++;
    if (out_last !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst2_pre: valid=%b last=%b, want 1 0", out_valid, out_last);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rst2_async: valid=%b inst=%h last=%b, want 0 0 0",
               out_valid, out_inst, out_last);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst2_ready: ready=%b, want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst2_no_second%0d: valid=%b ready=%b, want 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_li = 1'b0; in_op = 7'd0; in_rd = 5'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_imm = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    test_formats();
    test_li_stall();
    test_li_single();
    test_back_to_back();
    test_reset_in_second();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
